// File: rtl/serial_word_comparator.sv
// serial_word_comparator
// Framed serial three-way magnitude comparator. Two operand bit streams are
// consumed one qualified bit per cycle over a WIDTH-bit word. Bit order and
// number format are chosen on bit 0 of every word and held for the rest of it.
// One registered result (lt / eq / gt) plus a res_vld pulse follows each word.
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld,
    input  logic a,
    input  logic b,
    input  logic msb_first,
    input  logic is_signed,
    input  logic flush,
    output logic busy,
    output logic res_vld,
    output logic a_less_b,
    output logic a_eq_b,
    output logic a_greater_b
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("serial_word_comparator: WIDTH must be at least 2");
        end
    endgenerate

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Next "A < B so far" flag for one bit. MSB-first: the first differing
    // bit decides, except that a differing sign bit flips the sense.
    // LSB-first: the most recent differing bit decides, and the sign bit
    // (arriving last) again has inverted weight.
    function automatic logic lt_step(
        input logic msb,
        input logic sgn,
        input logic first,
        input logic last,
        input logic ab,
        input logic bb,
        input logic eq,
        input logic lt
    );
        logic res;
        if (msb) begin
            if (sgn && first) res = eq & ab & ~bb;
            else              res = lt | (eq & ~ab & bb);
        end else begin
            if (sgn && last)  res = (ab & ~bb) | ((ab ~^ bb) & lt);
            else              res = (~ab & bb) | ((ab ~^ bb) & lt);
        end
        return res;
    endfunction

    logic [CW-1:0] cnt;
    logic [CW-1:0] eff_cnt;
    logic [CW-1:0] cnt_nx;
    logic          m_msb;
    logic          m_sgn;
    logic          eq_r;
    logic          lt_r;
    logic          first;
    logic          last;
    logic          cur_msb;
    logic          cur_sgn;
    logic          eq_in;
    logic          lt_in;
    logic          eq_nx;
    logic          lt_nx;

    // Bit-position decode and running-flag update for the bit on the pins;
    // flush makes the current bit (if any) bit 0 of a fresh word.
    always_comb begin
        eff_cnt = flush ? '0 : cnt;
        first   = (eff_cnt == '0);
        last    = (eff_cnt == LAST);
        cur_msb = first ? msb_first : m_msb;
        cur_sgn = first ? is_signed : m_sgn;
        eq_in   = first ? 1'b1 : eq_r;
        lt_in   = first ? 1'b0 : lt_r;
        eq_nx   = eq_in & (a ~^ b);
        lt_nx   = lt_step(cur_msb, cur_sgn, first, last, a, b, eq_in, lt_in);
        if (vld) cnt_nx = last ? '0 : eff_cnt + CW'(1);
        else     cnt_nx = eff_cnt;
    end

    // Counter, latched mode, running flags and registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            busy        <= 1'b0;
            res_vld     <= 1'b0;
            m_msb       <= 1'b0;
            m_sgn       <= 1'b0;
            eq_r        <= 1'b1;
            lt_r        <= 1'b0;
            a_less_b    <= 1'b0;
            a_eq_b      <= 1'b1;
            a_greater_b <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            busy    <= (cnt_nx != '0);
            res_vld <= vld & last;
            if (vld && first) begin
                m_msb <= msb_first;
                m_sgn <= is_signed;
            end
            if (vld && !last) begin
                eq_r <= eq_nx;
                lt_r <= lt_nx;
            end else if (vld || flush) begin
                eq_r <= 1'b1;
                lt_r <= 1'b0;
            end
            if (vld && last) begin
                a_eq_b      <= eq_nx;
                a_less_b    <= lt_nx;
                a_greater_b <= ~eq_nx & ~lt_nx;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator: a WIDTH=4 instance for the
// per-feature scenarios and a WIDTH=8 instance for back-to-back words.
module tb_serial_word_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic vld4 = 0, a4 = 0, b4 = 0, msb4 = 0, sgn4 = 0, flush4 = 0;
    logic busy4, rv4, lt4, eq4, gt4;
    logic vld8 = 0, a8 = 0, b8 = 0, msb8 = 0, sgn8 = 0, flush8 = 0;
    logic busy8, rv8, lt8, eq8, gt8;

    int errors = 0;
    int checks = 0;
    int rv_cnt4 = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (rv4 === 1'b1) rv_cnt4 = rv_cnt4 + 1;

    serial_word_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .vld(vld4), .a(a4), .b(b4),
        .msb_first(msb4), .is_signed(sgn4), .flush(flush4),
        .busy(busy4), .res_vld(rv4), .a_less_b(lt4), .a_eq_b(eq4),
        .a_greater_b(gt4)
    );

    serial_word_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .vld(vld8), .a(a8), .b(b8),
        .msb_first(msb8), .is_signed(sgn8), .flush(flush8),
        .busy(busy8), .res_vld(rv8), .a_less_b(lt8), .a_eq_b(eq8),
        .a_greater_b(gt8)
    );

    // Drive one full 4-bit word on consecutive cycles; returns on the
    // falling edge after the last bit was accepted, with vld dropped.
    task automatic send_word4(input logic [3:0] wa, input logic [3:0] wb,
                              input logic m, input logic s);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vld4 = 1'b1; flush4 = 1'b0; msb4 = m; sgn4 = s;
            a4 = m ? wa[3-i] : wa[i];
            b4 = m ? wb[3-i] : wb[i];
        end
        @(negedge clk);
        vld4 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({rv4, busy4} !== 2'b00) begin errors++;
            $display("FAIL reset_ctl4: rv/busy=%b expected 00", {rv4, busy4}); end
        checks++; if ({lt4, eq4, gt4} !== 3'b010) begin errors++;
            $display("FAIL reset_res4: lt/eq/gt=%b expected 010", {lt4, eq4, gt4}); end
        checks++; if ({rv8, busy8, lt8, eq8, gt8} !== 5'b00010) begin errors++;
            $display("FAIL reset8: rv/busy/lt/eq/gt=%b expected 00010", {rv8, busy8, lt8, eq8, gt8}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_msb;
        send_word4(4'b1010, 4'b1001, 1'b1, 1'b0);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1001) begin errors++;
            $display("FAIL umsb_10_9: rv/lt/eq/gt=%b expected 1001", {rv4, lt4, eq4, gt4}); end
        @(negedge clk);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b0001) begin errors++;
            $display("FAIL umsb_hold: rv/lt/eq/gt=%b expected 0001", {rv4, lt4, eq4, gt4}); end
    endtask

    task automatic test_signed_msb;
        send_word4(4'b1110, 4'b0001, 1'b1, 1'b1);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1100) begin errors++;
            $display("FAIL smsb_m2_p1: rv/lt/eq/gt=%b expected 1100", {rv4, lt4, eq4, gt4}); end
        send_word4(4'b1110, 4'b0001, 1'b1, 1'b0);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1001) begin errors++;
            $display("FAIL umsb_14_1: rv/lt/eq/gt=%b expected 1001", {rv4, lt4, eq4, gt4}); end
    endtask

    task automatic test_lsb_first;
        send_word4(4'b0011, 4'b0101, 1'b0, 1'b0);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1100) begin errors++;
            $display("FAIL ulsb_3_5: rv/lt/eq/gt=%b expected 1100", {rv4, lt4, eq4, gt4}); end
        send_word4(4'b0100, 4'b1100, 1'b0, 1'b1);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1001) begin errors++;
            $display("FAIL slsb_p4_m4: rv/lt/eq/gt=%b expected 1001", {rv4, lt4, eq4, gt4}); end
        send_word4(4'b0100, 4'b1100, 1'b0, 1'b0);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1100) begin errors++;
            $display("FAIL ulsb_4_12: rv/lt/eq/gt=%b expected 1100", {rv4, lt4, eq4, gt4}); end
    endtask

    task automatic test_gapped_mode_hold;
        logic [3:0] wa;
        logic [3:0] wb;
        int c0;
        @(negedge clk); #1;
        c0 = rv_cnt4;
        wa = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            vld4 = 1'b1;
            if (i == 0) begin msb4 = 1'b1; sgn4 = 1'b0; end
            else begin msb4 = ~msb4; sgn4 = ~sgn4; end
            a4 = wa[3-i]; b4 = wa[3-i];
            @(negedge clk);
            vld4 = 1'b0;
            if (i < 3) begin
                checks++; if ({busy4, rv4} !== 2'b10) begin errors++;
                    $display("FAIL gap_busy bit%0d: busy/rv=%b expected 10", i, {busy4, rv4}); end
            end else begin
                checks++; if ({busy4, rv4, lt4, eq4, gt4} !== 5'b01010) begin errors++;
                    $display("FAIL gap_eq: busy/rv/lt/eq/gt=%b expected 01010", {busy4, rv4, lt4, eq4, gt4}); end
            end
        end
        @(negedge clk); #1;
        checks++; if (rv_cnt4 !== c0 + 1) begin errors++;
            $display("FAIL gap_pulses: got %0d expected %0d", rv_cnt4 - c0, 1); end
        // 1010 vs 1001 MSB-first unsigned; msb_first dropped after bit 0
        wa = 4'b1010; wb = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vld4 = 1'b1; sgn4 = 1'b0; msb4 = (i == 0);
            a4 = wa[3-i]; b4 = wb[3-i];
        end
        @(negedge clk);
        vld4 = 1'b0;
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1001) begin errors++;
            $display("FAIL mode_hold: rv/lt/eq/gt=%b expected 1001", {rv4, lt4, eq4, gt4}); end
    endtask

    task automatic test_flush;
        logic [3:0] wa;
        logic [3:0] wb;
        int c0;
        @(negedge clk); #1;
        c0 = rv_cnt4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vld4 = 1'b1; msb4 = 1'b1; sgn4 = 1'b0; a4 = 1'b1; b4 = 1'b0;
        end
        @(negedge clk);
        vld4 = 1'b0; flush4 = 1'b1;
        @(negedge clk);
        flush4 = 1'b0;
        checks++; if ({busy4, rv4, lt4, eq4, gt4} !== 5'b00001) begin errors++;
            $display("FAIL flush_only: busy/rv/lt/eq/gt=%b expected 00001", {busy4, rv4, lt4, eq4, gt4}); end
        // one stray bit, then flush+vld starts 0001 vs 0010 as a new word
        vld4 = 1'b1; a4 = 1'b1; b4 = 1'b0;
        wa = 4'b0001; wb = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++; if (busy4 !== 1'b1) begin errors++;
                    $display("FAIL flush_vld_busy: busy=%b expected 1", busy4); end
            end
            vld4 = 1'b1; flush4 = (i == 0); msb4 = 1'b1; sgn4 = 1'b0;
            a4 = wa[3-i]; b4 = wb[3-i];
        end
        @(negedge clk);
        vld4 = 1'b0;
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1100) begin errors++;
            $display("FAIL flush_vld_word: rv/lt/eq/gt=%b expected 1100", {rv4, lt4, eq4, gt4}); end
        @(negedge clk); #1;
        checks++; if (rv_cnt4 !== c0 + 1) begin errors++;
            $display("FAIL flush_pulses: got %0d expected %0d", rv_cnt4 - c0, 1); end
    endtask

    task automatic test_reset_midword;
        int c0;
        c0 = rv_cnt4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vld4 = 1'b1; msb4 = 1'b1; sgn4 = 1'b0; a4 = 1'b1; b4 = 1'b0;
        end
        @(negedge clk);
        vld4 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if ({busy4, rv4, lt4, eq4, gt4} !== 5'b00010) begin errors++;
            $display("FAIL mid_reset: busy/rv/lt/eq/gt=%b expected 00010", {busy4, rv4, lt4, eq4, gt4}); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rv_cnt4 !== c0) begin errors++;
            $display("FAIL mid_reset_pulses: got %0d expected 0", rv_cnt4 - c0); end
        send_word4(4'b0001, 4'b0000, 1'b1, 1'b0);
        checks++; if ({rv4, lt4, eq4, gt4} !== 4'b1001) begin errors++;
            $display("FAIL post_reset_word: rv/lt/eq/gt=%b expected 1001", {rv4, lt4, eq4, gt4}); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] wa [3];
        logic [7:0] wb [3];
        logic       wm [3];
        logic       ws [3];
        logic [2:0] exp_res;
        int w, i;
        // 0x80 vs 0x7F unsigned MSB: 128 > 127
        wa[0] = 8'h80; wb[0] = 8'h7F; wm[0] = 1'b1; ws[0] = 1'b0;
        // 0x05 vs 0xFB signed LSB: 5 > -5
        wa[1] = 8'h05; wb[1] = 8'hFB; wm[1] = 1'b0; ws[1] = 1'b1;
        // 0x80 vs 0x01 signed MSB: -128 < 1
        wa[2] = 8'h80; wb[2] = 8'h01; wm[2] = 1'b1; ws[2] = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++; if (rv8 !== (k % 8 == 0)) begin errors++;
                    $display("FAIL b2b_rv cyc%0d: rv=%b expected %b", k, rv8, (k % 8 == 0)); end
                if (k % 8 == 0) begin
                    w = k / 8 - 1;
                    if (ws[w]) exp_res = ($signed(wa[w]) < $signed(wb[w])) ? 3'b100 :
                                         (wa[w] == wb[w]) ? 3'b010 : 3'b001;
                    else       exp_res = (wa[w] < wb[w]) ? 3'b100 :
                                         (wa[w] == wb[w]) ? 3'b010 : 3'b001;
                    checks++; if ({lt8, eq8, gt8} !== exp_res) begin errors++;
                        $display("FAIL b2b_word%0d: lt/eq/gt=%b expected %b", w, {lt8, eq8, gt8}, exp_res); end
                end
            end
            if (k < 24) begin
                w = k / 8; i = k % 8;
                vld8 = 1'b1; msb8 = wm[w]; sgn8 = ws[w];
                a8 = wm[w] ? wa[w][7-i] : wa[w][i];
                b8 = wm[w] ? wb[w][7-i] : wb[w][i];
            end else begin
                vld8 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_msb;
        test_signed_msb;
        test_lsb_first;
        test_gapped_mode_hold;
        test_flush;
        test_reset_midword;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_comparator.md
# serial_word_comparator

Parametrised, framed serial magnitude comparator. Accepts two operand bit streams, one bit per qualified cycle, over a fixed word length `WIDTH`. Supports both bit orders (MSB-first / LSB-first) and both number formats (unsigned / two's-complement), selected per word. Emits one registered three-way result per completed word. It is the word-level successor of the single-mode serial comparators in the sequential-basics set, for use behind serialisers on narrow links.

## Interface

Parameters:
- `WIDTH`, 8: bits per word. Must be ≥ 2; elaboration error otherwise.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `vld`  in  1  qualifies `a`/`b` as the next bit of the current word.
- `a`  in  1  operand A serial bit.
- `b`  in  1  operand B serial bit.
- `msb_first`  in  1  bit order: 1 = MSB first, 0 = LSB first. Sampled on bit 0 of each word only.
- `is_signed`  in  1  1 = two's-complement, 0 = unsigned. Sampled on bit 0 of each word only.
- `flush`  in  1  abandons the partial word.
- `busy`  out  1  high while a word is partially received (bit counter ≠ 0).
- `res_vld`  out  1  one-cycle pulse: result outputs were updated.
- `a_less_b`  out  1  registered result: A < B.
- `a_eq_b`  out  1  registered result: A == B.
- `a_greater_b`  out  1  registered result: A > B.

## Operation

- State:
  - bit counter `cnt`, width `$clog2(WIDTH)`;
  - latched mode bits `m_msb` and `m_sgn`;
  - running flags `eq_r` and `lt_r`;
  - output registers.
- Accepted bit = `vld` high in a cycle, subject to the `flush` rule below. Cycles with `vld` low change nothing. Gaps of any length are allowed.
- On an accepted bit with `cnt == 0`:
  - mode is taken from the pins, not from `m_msb`/`m_sgn`;
  - `m_msb`/`m_sgn` are loaded for the rest of the word;
  - running flags are computed from reset values eq=1, lt=0.
- MSB-first update:
  - eq' = eq & (a == b);
  - lt' = lt | (eq & ~a & b).
  - Signed, bit 0 only (sign bit): lt' = eq & a & ~b.
- LSB-first update:
  - eq' = eq & (a == b);
  - lt' = (~a & b) | ((a == b) & lt).
  - Signed, last bit only (`cnt == WIDTH-1`, sign bit): lt' = (a & ~b) | ((a == b) & lt).
- Word completion (`cnt == WIDTH-1` and the bit is accepted):
  - next cycle, `a_eq_b` = eq', `a_less_b` = lt', `a_greater_b` = ~eq' & ~lt';
  - `res_vld` = 1 for that cycle;
  - `cnt` wraps to 0 and running flags return to eq=1, lt=0.
- Result outputs hold their value until the next completion. Exactly one of the three is high at all times after reset.
- `flush`:
  - `cnt` returns to 0 and running flags are cleared; outputs and `res_vld` are not affected.
  - If `vld` is high in the same cycle as `flush`, that bit is accepted as bit 0 of a fresh word. It uses the mode pins and `cnt` becomes 1.
- `busy` = (`cnt` ≠ 0), registered.

## Timing

- Reset values (`rst_n` low at a rising edge):
  - `cnt` = 0, `busy` = 0, `res_vld` = 0;
  - `a_eq_b` = 1, `a_less_b` = 0, `a_greater_b` = 0;
  - running flags eq=1, lt=0.
- Reset mid-word discards the partial word; no `res_vld` is produced for it.
- Latency: `res_vld` and the updated results appear 1 cycle after the clock edge that accepts the last bit.
- Throughput: back-to-back words with `vld` held high give one result every `WIDTH` cycles. The first bit of word N+1 may be accepted in the same cycle that word N's `res_vld` is high.
- Mode pins changing while `cnt` ≠ 0 have no effect on the current word.
- `res_vld` never stays high for two consecutive cycles unless `WIDTH` accepted bits arrive in between.

## Test plan

- Unsigned MSB-first, WIDTH=4: A=1010 (10), B=1001 (9), bits on 4 consecutive cycles -> `res_vld` one cycle after the 4th bit; `a_greater_b`=1, others 0.
- Signed MSB-first: A=1110 (-2), B=0001 (+1) -> `a_less_b`=1. Same bit patterns with `is_signed`=0 -> `a_greater_b`=1.
- LSB-first unsigned: A=0011 (3), B=0101 (5) -> `a_less_b`=1. Signed LSB-first: A=0100 (+4), B=1100 (-4) -> `a_greater_b`=1.
- Gapped equal word: A=B=0110 with `vld` low on alternate cycles -> `busy`=1 throughout; exactly one `res_vld`, after the 4th valid bit; `a_eq_b`=1. Mode pins toggled mid-word -> result unchanged.
- `flush` after 2 bits, then `flush`+`vld` together starting a word A=0001/B=0010 (MSB-first unsigned) -> only one `res_vld`, with `a_less_b`=1. `rst_n` low after 3 bits -> outputs return to eq=1, no `res_vld`.
- WIDTH=8, three back-to-back words (modes: MSB-unsigned, LSB-signed, MSB-signed) with `vld` held high -> `res_vld` every 8 cycles, each result matching a reference model.
